rx_uart: RTL and testbench

- Serial receiver that sits directly downstream of the transmit stage. It consumes the transmitter's serial line frame (start bit, data LSB first, optional parity bit, stop bit).
- Recovers the data word using an oversampling tick and presents it as a parallel word in the same {parity, data} layout the transmitter accepts.
- Flags parity and framing errors.
- Feeds the loopback checker and any downstream consumer through a one-cycle valid pulse; there is no backpressure.

---
 rtl/rx_uart_pkg.sv | 22 ++
 rtl/rx_uart_sync_2ff.sv | 24 ++
 rtl/rx_uart.sv | 127 ++++++++++++
 tb/tb_rx_uart.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_uart_pkg.sv
// Shared UART definitions: receiver state encoding, line-level constants
// and the frame-width helper used by both the transmitter and the receiver.
package rx_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Total bits on the line for one frame: start + data + optional parity + stop.
  function automatic int frame_width(input int data_width, input int parity_enabled);
    return data_width + parity_enabled + 2;
  endfunction

endpackage

// File: rtl/rx_uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// is a parameter so an idle-high line does not look like a start bit.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_uart.sv
// Oversampling UART receiver: recovers {parity, data} from the serial line,
// flags parity and framing errors, and announces each frame with a 1-clk pulse.
module rx_uart
  import rx_uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int PARITY_ODD       = 0,
  parameter int OVERSAMPLE       = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       sample_tick,
  input  logic                                       serial_in,
  output logic [INPUT_DATA_WIDTH+PARITY_ENABLED-1:0] o_data,
  output logic                                       o_valid,
  output logic                                       o_parity_err,
  output logic                                       o_frame_err,
  output logic                                       o_busy
);

  localparam int OUT_W = INPUT_DATA_WIDTH + PARITY_ENABLED;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(INPUT_DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(INPUT_DATA_WIDTH - 1);
  localparam logic             ODD_BIT   = (PARITY_ODD != 0);

  uart_state_t state, state_next;

  logic                        rx_s;
  logic [CNT_W-1:0]            tick_cnt;
  logic [IDX_W-1:0]            bit_idx;
  logic [INPUT_DATA_WIDTH-1:0] shift_reg;
  logic                        parity_bit;
  logic [OUT_W-1:0]            frame_word;
  logic                        parity_err;
  logic                        half_hit;
  logic                        full_hit;

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (rx_s)
  );

  assign half_hit = sample_tick && (tick_cnt == HALF_TICK);
  assign full_hit = sample_tick && (tick_cnt == LAST_TICK);

  generate
    if (PARITY_ENABLED != 0) begin : g_par
      assign frame_word = {parity_bit, shift_reg};
      assign parity_err = ((^shift_reg) ^ parity_bit) != ODD_BIT;
    end else begin : g_nopar
      assign frame_word = shift_reg;
      assign parity_err = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A stop bit sampled low parks the FSM in BREAK so a held-low line is not
  // decoded as a stream of back-to-back frames.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (sample_tick && rx_s == START_BIT) state_next = START;
      START:  if (half_hit) state_next = (rx_s == START_BIT) ? DATA : IDLE;
      DATA:   if (full_hit && bit_idx == LAST_BIT)
                state_next = (PARITY_ENABLED != 0) ? PARITY : STOP;
      PARITY: if (full_hit) state_next = STOP;
      STOP:   if (full_hit) state_next = (rx_s == STOP_BIT) ? IDLE : BREAK;
      BREAK:  if (sample_tick && rx_s == STOP_BIT) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt     <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      parity_bit   <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        START: begin
          bit_idx <= '0;
          if (sample_tick) tick_cnt <= half_hit ? '0 : tick_cnt + CNT_W'(1);
        end
        DATA, PARITY, STOP: begin
          if (sample_tick) tick_cnt <= full_hit ? '0 : tick_cnt + CNT_W'(1);
          if (full_hit) begin
            if (state == DATA) begin
              shift_reg <= {rx_s, shift_reg[INPUT_DATA_WIDTH-1:1]};
              bit_idx   <= bit_idx + IDX_W'(1);
            end else if (state == PARITY) begin
              parity_bit <= rx_s;
            end else begin
              o_valid      <= 1'b1;
              o_data       <= frame_word;
              o_parity_err <= parity_err;
              o_frame_err  <= (rx_s != STOP_BIT);
            end
          end
        end
        default: begin
          tick_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: a table of clean/parity-error frames sent back
// to back, plus hand sequences for false start, tick freeze, break and reset.
module tb_rx_uart;

  logic       clk;
  logic       reset;
  logic       sample_tick;
  logic       serial_in;
  logic [8:0] o_data;
  logic       o_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_busy;

  int checks = 0;
  int failures = 0;
  int valid_count = 0;
  int busy_cycles = 0;
  logic tick_en = 1'b1;
  int tick_div = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [8:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[6];

  rx_uart #(
    .INPUT_DATA_WIDTH(8),
    .PARITY_ENABLED  (1),
    .PARITY_ODD      (0),
    .OVERSAMPLE      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .serial_in    (serial_in),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tick every third clock, changed on the falling edge so it is stable
  // at the rising edge; tick_en lets a sequence freeze the receiver.
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_div == 2) begin
        sample_tick = tick_en;
        tick_div = 0;
      end else begin
        sample_tick = 1'b0;
        tick_div++;
      end
    end
  end

  always @(negedge clk) begin
    if (o_valid) valid_count++;
    if (o_busy) busy_cycles++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (sample_tick) c++;
    end
    #1;
  endtask

  task automatic send_level(input logic level, input int n);
    serial_in = level;
    wait_ticks(n);
  endtask

  // Serializes one frame exactly as the transmitter would: start, LSB first, parity, stop.
  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop);
    send_level(1'b0, 16);
    for (int i = 0; i < 8; i++) send_level(data[i], 16);
    send_level(par, 16);
    send_level(stop, 16);
  endtask

  initial begin
    int v0;
    int b0;
    logic [7:0] byte_val;

    vecs[0] = '{8'hA5, 1'b0, 9'h0A5, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 9'h13C, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 9'h101, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 9'h180, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 9'h0FF, 1'b0};
    vecs[5] = '{8'h07, 1'b0, 9'h007, 1'b1};

    reset = 1'b0;
    serial_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_data", 32'(o_data), 32'h0);
    checkOutput("reset_valid", 32'(o_valid), 32'h0);
    checkOutput("reset_perr", 32'(o_parity_err), 32'h0);
    checkOutput("reset_ferr", 32'(o_frame_err), 32'h0);
    checkOutput("reset_busy", 32'(o_busy), 32'h0);
    reset = 1'b1;
    wait_ticks(20);

    for (int k = 0; k < 6; k++) begin
      v0 = valid_count;
      applyStimulus(vecs[k].data, vecs[k].par, 1'b1);
      checkOutput($sformatf("vec%0d_pulses", k), 32'(valid_count - v0), 32'd1);
      checkOutput($sformatf("vec%0d_data", k), 32'(o_data), 32'(vecs[k].exp_data));
      checkOutput($sformatf("vec%0d_perr", k), 32'(o_parity_err), 32'(vecs[k].exp_perr));
      checkOutput($sformatf("vec%0d_ferr", k), 32'(o_frame_err), 32'h0);
      checkOutput($sformatf("vec%0d_busy", k), 32'(o_busy), 32'h0);
    end

    // False start: line low for only 3 ticks.
    wait_ticks(20);
    v0 = valid_count;
    b0 = busy_cycles;
    send_level(1'b0, 3);
    send_level(1'b1, 30);
    checkOutput("false_pulses", 32'(valid_count - v0), 32'd0);
    checkOutput("false_busy_seen", 32'(busy_cycles > b0), 32'd1);
    checkOutput("false_busy_end", 32'(o_busy), 32'h0);
    checkOutput("false_data_hold", 32'(o_data), 32'h007);
    checkOutput("false_perr_hold", 32'(o_parity_err), 32'h1);

    // Tick freeze in the middle of data bit 3 of 0xC3.
    v0 = valid_count;
    byte_val = 8'hC3;
    send_level(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        send_level(byte_val[i], 8);
        tick_en = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        checkOutput("freeze_busy", 32'(o_busy), 32'h1);
        checkOutput("freeze_pulses", 32'(valid_count - v0), 32'd0);
        tick_en = 1'b1;
        send_level(byte_val[i], 8);
      end else begin
        send_level(byte_val[i], 16);
      end
    end
    send_level(1'b0, 16);
    send_level(1'b1, 16);
    checkOutput("freeze_frame_pulses", 32'(valid_count - v0), 32'd1);
    checkOutput("freeze_frame_data", 32'(o_data), 32'h0C3);
    checkOutput("freeze_frame_perr", 32'(o_parity_err), 32'h0);

    // Framing error: 0x55, stop bit low, line held low for 40 ticks.
    wait_ticks(10);
    v0 = valid_count;
    byte_val = 8'h55;
    send_level(1'b0, 16);
    for (int i = 0; i < 8; i++) send_level(byte_val[i], 16);
    send_level(1'b0, 16);
    send_level(1'b0, 40);
    checkOutput("break_pulses", 32'(valid_count - v0), 32'd1);
    checkOutput("break_data", 32'(o_data), 32'h055);
    checkOutput("break_ferr", 32'(o_frame_err), 32'h1);
    checkOutput("break_perr", 32'(o_parity_err), 32'h0);
    checkOutput("break_busy_held", 32'(o_busy), 32'h1);
    send_level(1'b1, 20);
    checkOutput("break_no_second", 32'(valid_count - v0), 32'd1);
    checkOutput("break_busy_end", 32'(o_busy), 32'h0);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x12.
    v0 = valid_count;
    send_level(1'b0, 16);
    for (int i = 0; i < 4; i++) send_level(1'b1, 16);
    send_level(1'b1, 8);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_data", 32'(o_data), 32'h0);
    checkOutput("rst_mid_ferr", 32'(o_frame_err), 32'h0);
    checkOutput("rst_mid_busy", 32'(o_busy), 32'h0);
    checkOutput("rst_mid_valid", 32'(o_valid), 32'h0);
    serial_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_ticks(200);
    checkOutput("rst_no_pulse", 32'(valid_count - v0), 32'd0);
    v0 = valid_count;
    applyStimulus(8'h12, 1'b0, 1'b1);
    checkOutput("post_rst_pulses", 32'(valid_count - v0), 32'd1);
    checkOutput("post_rst_data", 32'(o_data), 32'h012);
    checkOutput("post_rst_perr", 32'(o_parity_err), 32'h0);
    checkOutput("post_rst_ferr", 32'(o_frame_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
